// File: rtl/dot_matrix_scan.sv
// dot_matrix_scan: row-multiplexed LED matrix driver with a
// double-buffered frame, per-row blanking and PWM brightness.
module dot_matrix_scan #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int ROW_TICKS   = 100000,
  parameter int BLANK_TICKS = 50,
  parameter int BRIGHT_W    = 4,
  parameter int ROW_ACT_LOW = 0,
  parameter int COL_ACT_LOW = 0
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     i_En,
  input  logic [ROWS*COLS-1:0]     i_Data,
  input  logic [BRIGHT_W-1:0]      i_Bright,
  input  logic                     i_Load,
  output logic                     o_LoadAck,
  output logic [ROWS-1:0]          o_DM_Row,
  output logic [COLS-1:0]          o_DM_Col,
  output logic [$clog2(ROWS)-1:0]  o_RowIdx,
  output logic                     o_fDone
);

  localparam int CW   = $clog2(ROW_TICKS);
  localparam int IW   = $clog2(ROWS);
  localparam int STEP = (ROW_TICKS - BLANK_TICKS) >> BRIGHT_W;
  localparam int PW   = CW + BRIGHT_W;
  localparam logic RINV = (ROW_ACT_LOW != 0);
  localparam logic CINV = (COL_ACT_LOW != 0);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 pend_q, pend_d;
  logic [ROWS*COLS-1:0] fb_q, fb_d;
  logic [BRIGHT_W-1:0]  br_q, br_d;
  logic [ROWS-1:0]      row_q, row_d;
  logic [COLS-1:0]      col_q, col_d;
  logic [IW-1:0]        ridx_q, ridx_d;
  logic                 done_q, done_d;
  logic                 ack_q, ack_d;

  logic                 slot_end;
  logic                 last_row;
  logic                 boundary;
  logic                 take;
  logic [CW-1:0]        dcnt;
  logic [PW-1:0]        prod;
  logic                 pwm_on;
  logic                 col_on;
  logic [ROWS-1:0]      row_on;
  logic [COLS-1:0]      col_data;

  // Slot position, PWM window and load decision from current state.
  always_comb begin
    slot_end = (cnt_q == CW'(ROW_TICKS - 1));
    last_row = (idx_q == IW'(ROWS - 1));
    boundary = i_En & slot_end & last_row;
    take     = (boundary | ~i_En) & (pend_q | i_Load);
    dcnt     = cnt_q - CW'(BLANK_TICKS);
    prod     = PW'(STEP) * PW'(br_q);
    pwm_on   = (&br_q) | (PW'(dcnt) < prod);
    col_on   = (cnt_q >= CW'(BLANK_TICKS)) & pwm_on;
    row_on   = ROWS'(1) << idx_q;
    col_data = fb_q[COLS*idx_q +: COLS];
  end

  // Next-state: scan counters, display image and load handshake.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    row_d  = {ROWS{RINV}};
    col_d  = {COLS{CINV}};
    ridx_d = '0;
    done_d = 1'b0;
    if (i_En) begin
      cnt_d  = slot_end ? '0 : cnt_q + CW'(1);
      if (slot_end)
        idx_d = last_row ? '0 : idx_q + IW'(1);
      row_d  = row_on ^ {ROWS{RINV}};
      col_d  = (col_on ? col_data : '0) ^ {COLS{CINV}};
      ridx_d = idx_q;
      done_d = boundary;
    end else begin
      cnt_d = '0;
      idx_d = '0;
    end
    ack_d  = take;
    pend_d = take ? 1'b0 : (pend_q | i_Load);
    fb_d   = take ? i_Data : fb_q;
    br_d   = take ? i_Bright : br_q;
  end

  // State and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
      fb_q   <= '0;
      br_q   <= '1;
      row_q  <= {ROWS{RINV}};
      col_q  <= {COLS{CINV}};
      ridx_q <= '0;
      done_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      fb_q   <= fb_d;
      br_q   <= br_d;
      row_q  <= row_d;
      col_q  <= col_d;
      ridx_q <= ridx_d;
      done_q <= done_d;
      ack_q  <= ack_d;
    end
  end

  assign o_DM_Row  = row_q;
  assign o_DM_Col  = col_q;
  assign o_RowIdx  = ridx_q;
  assign o_fDone   = done_q;
  assign o_LoadAck = ack_q;

endmodule

// File: tb/tb_dot_matrix_scan.sv
// tb_dot_matrix_scan: directed bench for the dot-matrix driver,
// one active-high and one active-low instance on shared inputs.
module tb_dot_matrix_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] data;
  logic [1:0]  bright;
  logic        load;

  logic        ack, ack_n;
  logic [3:0]  row, row_n;
  logic [3:0]  col, col_n;
  logic [1:0]  ridx, ridx_n;
  logic        fdone, fdone_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dot_matrix_scan #(
    .ROWS(4), .COLS(4), .ROW_TICKS(20), .BLANK_TICKS(2),
    .BRIGHT_W(2), .ROW_ACT_LOW(0), .COL_ACT_LOW(0)
  ) dut (
    .i_Clk(clk), .i_Rst(rst_n), .i_En(en), .i_Data(data),
    .i_Bright(bright), .i_Load(load), .o_LoadAck(ack),
    .o_DM_Row(row), .o_DM_Col(col), .o_RowIdx(ridx),
    .o_fDone(fdone)
  );

  dot_matrix_scan #(
    .ROWS(4), .COLS(4), .ROW_TICKS(20), .BLANK_TICKS(2),
    .BRIGHT_W(2), .ROW_ACT_LOW(1), .COL_ACT_LOW(1)
  ) dut_n (
    .i_Clk(clk), .i_Rst(rst_n), .i_En(en), .i_Data(data),
    .i_Bright(bright), .i_Load(load), .o_LoadAck(ack_n),
    .o_DM_Row(row_n), .o_DM_Col(col_n), .o_RowIdx(ridx_n),
    .o_fDone(fdone_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fdone(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (fdone === 1'b1) ok = 1'b1;
    end
  endtask

  // Expected row drive at frame position p (0..79).
  function automatic logic [3:0] exp_row(input int p);
    logic [3:0] one;
    one = 4'b0001;
    return one << ((p / 20) % 4);
  endfunction

  // Expected column drive for image img, brightness b, position p.
  function automatic logic [3:0] exp_col(input logic [15:0] img,
                                         input int b, input int p);
    int r, c;
    r = (p / 20) % 4;
    c = p % 20;
    if (c < 2) return 4'h0;
    if (b == 3 || (c - 2) < 4 * b) return img[4*r +: 4];
    return 4'h0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; data = '0; bright = '0; load = 1'b0;
    repeat (3) tick();
    checks++;
    if (row !== 4'h0 || col !== 4'h0) begin
      errors++;
      $display("FAIL reset_hi got row=%b col=%b want 0000 0000",
               row, col);
    end
    checks++;
    if (row_n !== 4'hF || col_n !== 4'hF) begin
      errors++;
      $display("FAIL reset_lo got row=%b col=%b want 1111 1111",
               row_n, col_n);
    end
    checks++;
    if (ack !== 1'b0 || fdone !== 1'b0 || ridx !== 2'd0) begin
      errors++;
      $display("FAIL reset_ctl got ack=%b done=%b idx=%0d want 0 0 0",
               ack, fdone, ridx);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    data = 16'h8421; bright = 2'd3; load = 1'b1;
    tick();
    load = 1'b0;
    wait_fdone(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_fdone got timeout want pulse");
    end
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL basic_ack got %b want 1", ack);
    end
    for (int i = 0; i < 160; i++) begin
      int p;
      p = i % 80;
      tick();
      checks++;
      if (row !== exp_row(p)) begin
        errors++;
        $display("FAIL basic_row p=%0d got %b want %b",
                 p, row, exp_row(p));
      end
      checks++;
      if (col !== exp_col(16'h8421, 3, p)) begin
        errors++;
        $display("FAIL basic_col p=%0d got %b want %b",
                 p, col, exp_col(16'h8421, 3, p));
      end
      checks++;
      if (ridx !== 2'(p / 20)) begin
        errors++;
        $display("FAIL basic_idx p=%0d got %0d want %0d",
                 p, ridx, p / 20);
      end
      checks++;
      if (fdone !== (p == 79) || ack !== 1'b0) begin
        errors++;
        $display("FAIL basic_done p=%0d got done=%b ack=%b want %b 0",
                 p, fdone, ack, (p == 79));
      end
    end
  endtask

  task automatic test_midframe();
    data = 16'hFFFF; bright = 2'd3;
    for (int p = 0; p < 80; p++) begin
      load = (p == 25 || p == 40);
      tick();
      checks++;
      if (col !== exp_col(16'h8421, 3, p)) begin
        errors++;
        $display("FAIL mid_old_col p=%0d got %b want %b",
                 p, col, exp_col(16'h8421, 3, p));
      end
      checks++;
      if (ack !== (p == 79) || fdone !== (p == 79)) begin
        errors++;
        $display("FAIL mid_ack p=%0d got ack=%b done=%b want %b",
                 p, ack, fdone, (p == 79));
      end
    end
    load = 1'b0;
    for (int p = 0; p < 80; p++) begin
      tick();
      checks++;
      if (col !== exp_col(16'hFFFF, 3, p)) begin
        errors++;
        $display("FAIL mid_new_col p=%0d got %b want %b",
                 p, col, exp_col(16'hFFFF, 3, p));
      end
      checks++;
      if (ack !== 1'b0) begin
        errors++;
        $display("FAIL mid_second_ack p=%0d got %b want 0", p, ack);
      end
    end
  endtask

  task automatic test_boundary_load();
    data = 16'h8421; bright = 2'd3;
    for (int p = 0; p < 80; p++) begin
      load = (p == 79);
      tick();
      checks++;
      if (col !== exp_col(16'hFFFF, 3, p)) begin
        errors++;
        $display("FAIL bnd_old_col p=%0d got %b want %b",
                 p, col, exp_col(16'hFFFF, 3, p));
      end
      checks++;
      if (ack !== (p == 79) || fdone !== (p == 79)) begin
        errors++;
        $display("FAIL bnd_ack p=%0d got ack=%b done=%b want %b",
                 p, ack, fdone, (p == 79));
      end
    end
    load = 1'b0;
    for (int p = 0; p < 80; p++) begin
      tick();
      checks++;
      if (col !== exp_col(16'h8421, 3, p)) begin
        errors++;
        $display("FAIL bnd_new_col p=%0d got %b want %b",
                 p, col, exp_col(16'h8421, 3, p));
      end
      checks++;
      if (ack !== 1'b0) begin
        errors++;
        $display("FAIL bnd_pending p=%0d got ack=%b want 0", p, ack);
      end
    end
  endtask

  task automatic test_brightness();
    int blist[4];
    blist = '{1, 2, 3, 0};
    foreach (blist[k]) begin
      bit ok;
      data = 16'hFFFF; bright = 2'(blist[k]); load = 1'b1;
      tick();
      load = 1'b0;
      wait_fdone(ok);
      checks++;
      if (!ok || ack !== 1'b1) begin
        errors++;
        $display("FAIL bright_ack b=%0d got ok=%b ack=%b want 1 1",
                 blist[k], ok, ack);
      end
      for (int p = 0; p < 20; p++) begin
        tick();
        checks++;
        if (col !== exp_col(16'hFFFF, blist[k], p)) begin
          errors++;
          $display("FAIL bright_col b=%0d p=%0d got %b want %b",
                   blist[k], p, col, exp_col(16'hFFFF, blist[k], p));
        end
      end
    end
  endtask

  task automatic test_enable();
    bit ok;
    data = 16'h8421; bright = 2'd3; load = 1'b1;
    tick();
    load = 1'b0;
    wait_fdone(ok);
    checks++;
    if (!ok || ack !== 1'b1) begin
      errors++;
      $display("FAIL en_preload got ok=%b ack=%b want 1 1", ok, ack);
    end
    for (int p = 0; p < 47; p++) begin
      tick();
      checks++;
      if (col !== exp_col(16'h8421, 3, p) || row !== exp_row(p)) begin
        errors++;
        $display("FAIL en_scan p=%0d got row=%b col=%b want %b %b",
                 p, row, col, exp_row(p), exp_col(16'h8421, 3, p));
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if (row !== 4'h0 || col !== 4'h0 || ridx !== 2'd0) begin
      errors++;
      $display("FAIL en_off got row=%b col=%b idx=%0d want 0 0 0",
               row, col, ridx);
    end
    checks++;
    if (row_n !== 4'hF || col_n !== 4'hF) begin
      errors++;
      $display("FAIL en_off_lo got row=%b col=%b want 1111 1111",
               row_n, col_n);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (row !== 4'h0 || fdone !== 1'b0) begin
        errors++;
        $display("FAIL en_idle i=%0d got row=%b done=%b want 0 0",
                 i, row, fdone);
      end
    end
    data = 16'hFFFF; bright = 2'd3; load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL en_load_ack got %b want 1", ack);
    end
    tick();
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL en_load_ack_pulse got %b want 0", ack);
    end
    en = 1'b1;
    for (int p = 0; p < 22; p++) begin
      tick();
      checks++;
      if (row !== exp_row(p) || col !== exp_col(16'hFFFF, 3, p)) begin
        errors++;
        $display("FAIL en_restart p=%0d got row=%b col=%b want %b %b",
                 p, row, col, exp_row(p), exp_col(16'hFFFF, 3, p));
      end
    end
  endtask

  task automatic test_polarity();
    bit ok;
    wait_fdone(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pol_fdone got timeout want pulse");
    end
    tick();
    checks++;
    if (row_n !== 4'b1110 || col_n !== 4'b1111) begin
      errors++;
      $display("FAIL pol_blank got row=%b col=%b want 1110 1111",
               row_n, col_n);
    end
    checks++;
    if (row !== 4'b0001 || col !== 4'b0000) begin
      errors++;
      $display("FAIL pol_blank_hi got row=%b col=%b want 0001 0000",
               row, col);
    end
    repeat (2) tick();
    checks++;
    if (row_n !== 4'b1110 || col_n !== 4'b0000) begin
      errors++;
      $display("FAIL pol_lit got row=%b col=%b want 1110 0000",
               row_n, col_n);
    end
  endtask

  task automatic test_async_reset();
    repeat (23) tick();
    checks++;
    if (row !== 4'b0010 || col !== 4'hF || ridx !== 2'd1) begin
      errors++;
      $display("FAIL ares_pre got row=%b col=%b idx=%0d want 0010 1111 1",
               row, col, ridx);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (row !== 4'h0 || col !== 4'h0 || ridx !== 2'd0) begin
      errors++;
      $display("FAIL ares_hi got row=%b col=%b idx=%0d want 0 0 0",
               row, col, ridx);
    end
    checks++;
    if (row_n !== 4'hF || col_n !== 4'hF) begin
      errors++;
      $display("FAIL ares_lo got row=%b col=%b want 1111 1111",
               row_n, col_n);
    end
    tick();
    rst_n = 1'b1;
    for (int p = 0; p < 40; p++) begin
      tick();
      checks++;
      if (row !== exp_row(p) || col !== 4'h0 || fdone !== 1'b0) begin
        errors++;
        $display("FAIL ares_clear p=%0d got row=%b col=%b done=%b want %b 0000 0",
                 p, row, col, fdone, exp_row(p));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe();
    test_boundary_load();
    test_brightness();
    test_enable();
    test_polarity();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
